// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake and an iterative
// shift-add multiplier.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         request strobe; accepted only while idle
//   select[2:0]   opcode, latched with start
//   A, B          operands (B is the left operand), latched with start
//   busy          high while a multiply is in progress
//   done          one-cycle pulse when out/flags are updated
//   out           result register
//   z_flag        result == 0
//   c_flag        carry / borrow / multiply overflow
//   out_hi        upper product half (only with ALU_SEQ_MUL_HI_EN)
//
// Optional feature macro: ALU_SEQ_MUL_HI_EN
//   Defined:   adds out_hi; z_flag for MUL covers the full 2*WIDTH product.
//   Undefined: no out_hi; z_flag for MUL covers the low WIDTH bits only.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             z_flag,
`ifdef ALU_SEQ_MUL_HI_EN
  output logic             c_flag,
  output logic [WIDTH-1:0] out_hi
`else
  output logic             c_flag
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_PASSA = 3'b011;
  localparam logic [2:0] OP_PASSB = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef ALU_SEQ_MUL_HI_EN
  logic [WIDTH-1:0]   hi_q, hi_d;
`endif

  // Single-cycle datapath, evaluated on the live inputs.
  logic [WIDTH:0]     add_c;
  logic [WIDTH:0]     sub_c;
  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_cy_c;

  always_comb begin
    add_c     = {1'b0, B} + {1'b0, A};
    sub_c     = {1'b0, B} - {1'b0, A};
    alu_res_c = '0;
    alu_cy_c  = 1'b0;
    case (select)
      OP_ADD:   begin alu_res_c = add_c[WIDTH-1:0]; alu_cy_c = add_c[WIDTH]; end
      // The extra bit of the widened difference is set exactly when B < A.
      OP_SUB:   begin alu_res_c = sub_c[WIDTH-1:0]; alu_cy_c = sub_c[WIDTH]; end
      OP_PASSA: alu_res_c = A;
      OP_PASSB: alu_res_c = B;
      OP_AND:   alu_res_c = B & A;
      OP_OR:    alu_res_c = B | A;
      OP_XOR:   alu_res_c = B ^ A;
      default:  alu_res_c = '0;
    endcase
  end

  // Multiply step: partial products for the current and the following bit.
  logic [PW-1:0]      mcand_ext_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [PW-1:0]      acc_step_c;
  logic [PW-1:0]      prod_c;
  logic               last_c;

  always_comb begin
    mcand_ext_c = {{WIDTH{1'b0}}, mcand_q};
    cnt_inc_c   = cnt_q + CNT_W'(1);
    acc_step_c  = acc_q + (mplier_q[0] ? (mcand_ext_c << cnt_q) : '0);
    // The start cycle counts toward the fixed latency, so the final MUL cycle
    // retires two multiplier bits to cover all WIDTH bits in WIDTH-1 steps.
    prod_c      = acc_step_c + (mplier_q[1] ? (mcand_ext_c << cnt_inc_c) : '0);
    last_c      = (cnt_inc_c == CNT_W'(WIDTH - 1));
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    z_d      = z_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_MUL_HI_EN
    hi_d     = hi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (select == OP_MUL) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else begin
            out_d  = alu_res_c;
            z_d    = (alu_res_c == '0);
            c_d    = alu_cy_c;
            done_d = 1'b1;
`ifdef ALU_SEQ_MUL_HI_EN
            hi_d   = '0;
`endif
          end
        end
      end

      S_MUL: begin
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_inc_c;
        acc_d    = acc_step_c;
        if (last_c) begin
          acc_d   = prod_c;
          out_d   = prod_c[WIDTH-1:0];
          c_d     = |prod_c[PW-1:WIDTH];
`ifdef ALU_SEQ_MUL_HI_EN
          hi_d    = prod_c[PW-1:WIDTH];
          z_d     = (prod_c == '0);
`else
          z_d     = (prod_c[WIDTH-1:0] == '0);
`endif
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_HI_EN
      hi_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      z_q      <= z_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_SEQ_MUL_HI_EN
      hi_q     <= hi_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign z_flag = z_q;
  assign c_flag = c_q;
`ifdef ALU_SEQ_MUL_HI_EN
  assign out_hi = hi_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   select;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         z_flag;
  logic         c_flag;
`ifdef ALU_SEQ_MUL_HI_EN
  logic [W-1:0] out_hi;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .select (select),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .z_flag (z_flag),
`ifdef ALU_SEQ_MUL_HI_EN
    .c_flag (c_flag),
    .out_hi (out_hi)
`else
    .c_flag (c_flag)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; select = 3'b000; A = '0; B = '0;
    tick(); tick();
    vectors++;
    if ({out, z_flag, c_flag, busy, done} !== {16'h0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset: out=%h z=%b c=%b busy=%b done=%b, want all zero",
               out, z_flag, c_flag, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    start = 1'b1; select = 3'b000; A = 16'h0001; B = 16'hFFFF;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, out, z_flag, c_flag} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL add_wrap: done=%b out=%h z=%b c=%b, want 1 0000 1 1",
               done, out, z_flag, c_flag);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL add_done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_sub();
    start = 1'b1; select = 3'b001; A = 16'd5; B = 16'd3;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, out, z_flag, c_flag} !== {1'b1, 16'hFFFE, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL sub_borrow: done=%b out=%h z=%b c=%b, want 1 fffe 0 1",
               done, out, z_flag, c_flag);
    end
    tick();
  endtask

  task automatic test_logic_ops();
    logic [2:0]  op;
    logic [15:0] a, b, eo;
    logic        ez;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0:       begin op = 3'b011; a = 16'h1234; b = 16'hABCD; eo = 16'h1234; ez = 1'b0; end
        1:       begin op = 3'b100; a = 16'h1234; b = 16'hABCD; eo = 16'hABCD; ez = 1'b0; end
        2:       begin op = 3'b101; a = 16'h0F0F; b = 16'hF0F0; eo = 16'h0000; ez = 1'b1; end
        default: begin op = 3'b110; a = 16'h0F0F; b = 16'hF0F0; eo = 16'hFFFF; ez = 1'b0; end
      endcase
      start = 1'b1; select = op; A = a; B = b;
      tick();
      start = 1'b0;
      vectors++;
      if ({done, out, z_flag, c_flag} !== {1'b1, eo, ez, 1'b0}) begin
        miscompares++;
        $display("FAIL logic_op%0d: done=%b out=%h z=%b c=%b, want 1 %h %b 0",
                 op, done, out, z_flag, c_flag, eo, ez);
      end
      tick();
    end
  endtask

  task automatic test_mul_latency();
    logic [15:0] a, b, eo, eh;
    logic        ez, ec;
    int          done_at;
    int          busy_low;
    for (int v = 0; v < 3; v++) begin
      case (v)
        0:       begin a = 16'h0100; b = 16'h0100; eo = 16'h0000; eh = 16'h0001; ec = 1'b1; end
        1:       begin a = 16'h0000; b = 16'h1234; eo = 16'h0000; eh = 16'h0000; ec = 1'b0; end
        default: begin a = 16'hFFFF; b = 16'hFFFF; eo = 16'h0001; eh = 16'hFFFE; ec = 1'b1; end
      endcase
`ifdef ALU_SEQ_MUL_HI_EN
      ez = ({eh, eo} == 32'h0);
`else
      ez = (eo == 16'h0);
`endif
      start = 1'b1; select = 3'b010; A = a; B = b;
      tick();
      start = 1'b0;
      done_at = 0;
      busy_low = 0;
      for (int k = 1; k <= 40 && done_at == 0; k++) begin
        if (done === 1'b1) done_at = k;
        else begin
          if (busy !== 1'b1) busy_low++;
          tick();
        end
      end
      vectors++;
      if (done_at != 16) begin
        miscompares++;
        $display("FAIL mul%0d_latency: done after %0d cycles, want 16", v, done_at);
      end
      vectors++;
      if (busy_low != 0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL mul%0d_busy: busy low on %0d MUL cycles, busy at done=%b, want 0/0",
                 v, busy_low, busy);
      end
      vectors++;
      if ({out, z_flag, c_flag} !== {eo, ez, ec}) begin
        miscompares++;
        $display("FAIL mul%0d_result: out=%h z=%b c=%b, want %h %b %b",
                 v, out, z_flag, c_flag, eo, ez, ec);
      end
`ifdef ALU_SEQ_MUL_HI_EN
      vectors++;
      if (out_hi !== eh) begin
        miscompares++;
        $display("FAIL mul%0d_hi: out_hi=%h, want %h", v, out_hi, eh);
      end
`endif
      tick();
    end
  endtask

  task automatic test_ignored_start();
    int pulses = 0;
    int done_at = 0;
    start = 1'b1; select = 3'b010; A = 16'd3; B = 16'd7;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (done === 1'b1) begin
        pulses++;
        if (done_at == 0) done_at = k;
      end
      if (k == 4) begin
        start = 1'b1; select = 3'b000; A = 16'hFFFF; B = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    vectors++;
    if (pulses != 1 || done_at != 16) begin
      miscompares++;
      $display("FAIL mul_ignore_start: %0d done pulses (first at %0d), want 1 at 16",
               pulses, done_at);
    end
    vectors++;
    if ({out, z_flag, c_flag} !== {16'h0015, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mul_operand_hold: out=%h z=%b c=%b, want 0015 0 0",
               out, z_flag, c_flag);
    end
  endtask

  task automatic test_reset_mid_mul();
    int pulses = 0;
    start = 1'b1; select = 3'b010; A = 16'h00FF; B = 16'h00FF;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({out, z_flag, c_flag, busy, done} !== {16'h0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL mul_abort_state: out=%h z=%b c=%b busy=%b done=%b, want all zero",
               out, z_flag, c_flag, busy, done);
    end
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL mul_abort_quiet: %0d cycles with done/busy after abort, want 0", pulses);
    end
    start = 1'b1; select = 3'b000; A = 16'd1; B = 16'd2;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, out, z_flag, c_flag} !== {1'b1, 16'h0003, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL add_after_abort: done=%b out=%h z=%b c=%b, want 1 0003 0 0",
               done, out, z_flag, c_flag);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; select = 3'b000; A = 16'd2; B = 16'd3;
    tick();
    vectors++;
    if ({done, out} !== {1'b1, 16'h0005}) begin
      miscompares++;
      $display("FAIL b2b_add: done=%b out=%h, want 1 0005", done, out);
    end
    select = 3'b111; A = 16'hF0F0; B = 16'hFFFF;
    tick();
    start = 1'b0;
    vectors++;
    if ({done, out, z_flag, c_flag} !== {1'b1, 16'h0F0F, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_xor: done=%b out=%h z=%b c=%b, want 1 0f0f 0 0",
               done, out, z_flag, c_flag);
    end
    tick();
    vectors++;
    if ({done, out} !== {1'b0, 16'h0F0F}) begin
      miscompares++;
      $display("FAIL b2b_hold: done=%b out=%h, want 0 0f0f", done, out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_ops();
    test_mul_latency();
    test_ignored_start();
    test_reset_mid_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit ALU.
- Operand width is configurable, the op set grows to 8 opcodes, and there is a start/busy/done handshake.
- Multiply is an iterative shift-add sequence (multi-cycle). All other ops complete in one cycle.
- Zero and carry flags are registered for every op. The block sits between the register file/accumulator and the datapath control FSM.

Parameters:
- WIDTH, 16, operand and result width in bits (legal range 4..32).
- CNT_W, $clog2(WIDTH+1), multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- select  input  3  opcode; latched with start.
- A  input  WIDTH  operand A; latched with start.
- B  input  WIDTH  operand B; latched with start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when out/flags are updated.
- out  output  WIDTH  result register.
- z_flag  output  1  registered: result == 0.
- c_flag  output  1  registered carry/borrow.

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is synchronous and active-high on rst.
  - On reset: out=0, z_flag=0, c_flag=0, busy=0, done=0, FSM=IDLE, counter=0, internal accumulator cleared.
- Opcodes (B is the left operand, matching the existing ALU):
  - 000 ADD: out = B+A. c_flag = carry out of bit WIDTH-1.
  - 001 SUB: out = B-A (mod 2^WIDTH). c_flag = 1 iff B<A unsigned (borrow).
  - 010 MUL: out = low WIDTH bits of B*A, unsigned. c_flag = 1 iff the upper WIDTH product bits are nonzero (overflow).
  - 011 PASS A: out = A. c_flag = 0.
  - 100 PASS B: out = B. c_flag = 0.
  - 101 AND, 110 OR, 111 XOR: bitwise on B,A. c_flag = 0.
- z_flag = (out_next == 0) for every opcode, including MUL and PASS.
- FSM states: IDLE, MUL.
  - IDLE, start=1, op≠010: compute from the live inputs and register out/z/c. done=1 on the next cycle. Latency 1. Stay in IDLE.
  - IDLE, start=1, op=010:
    - Latch A (multiplicand) and B (multiplier) into shift registers. Clear the 2*WIDTH accumulator and set counter=0.
    - busy=1 from the next cycle. Go to MUL.
  - MUL, each cycle:
    - If multiplier LSB=1: acc += multiplicand << counter.
    - Shift the multiplier right. Increment the counter.
    - When counter reaches WIDTH-1 on this cycle: write out/flags, set done=1, busy=0, return to IDLE.
    - Total latency from the start cycle to the done pulse = WIDTH cycles; WIDTH=16 gives done 16 cycles after start.
  - start while busy=1 is ignored. No queueing. Operands and select changes during MUL have no effect.
  - start on the same cycle done is high (IDLE re-entered) is accepted normally, so back-to-back ops are supported.
- Outputs and flags hold their last value between completions. done is high for exactly one cycle per accepted request.
- rst during MUL aborts the operation: no done pulse, outputs are cleared per the reset values.
- Boundary: MUL with A=0 or B=0 still takes the full WIDTH cycles (fixed latency, no early exit).

Optional Feature:
- Macro ALU_SEQ_MUL_HI_EN.
- Defined:
  - Adds output port out_hi [WIDTH-1:0], the upper WIDTH bits of the MUL product.
  - out_hi is written on MUL completion and cleared to 0 by reset and by any non-MUL completion.
  - z_flag for MUL covers the full 2*WIDTH product.
- Undefined:
  - No out_hi port. Upper product bits are used only for c_flag.
  - z_flag for MUL covers the low WIDTH bits only.

Test Plan (WIDTH=16):
- Reset, then ADD: rst high 2 cycles, then start, op=000, A=0x0001, B=0xFFFF -> next cycle done=1, out=0x0000, z=1, c=1.
- SUB with borrow: op=001, A=5, B=3 -> out=0xFFFE, z=0, c=1, done after 1 cycle.
- MUL fixed latency: op=010, A=0x0100, B=0x0100 ->
  - busy=1 for the MUL cycles; done exactly 16 cycles after start.
  - out=0x0000, z=1, c=1.
  - With ALU_SEQ_MUL_HI_EN: out_hi=0x0001, z=0.
- Ignored start and operand hold during MUL: start op=010, A=3, B=7. On cycle 4, pulse start with op=000 and change A/B -> single done pulse, out=21 (0x0015), z=0, c=0.
- Reset mid-multiply: start MUL A=0x00FF, B=0x00FF. Assert rst on cycle 8 -> no done pulse; out=0, busy=0, flags=0; a following ADD A=1, B=2 gives out=3 after 1 cycle.
- Back-to-back and logic ops: start XOR A=0xF0F0, B=0xFFFF on the cycle done rises from a prior ADD -> out=0x0F0F, c=0, done pulses on consecutive completions.
